// File: rtl/qtz_level_reader.sv
// qtz_level_reader
// Read side of the quantized level-HV bank. Each unsigned feature sample is
// quantized to a level 0..8. The stored hypervector for that level is returned
// with the sample's feature index and a frame-last flag. Samples pass through
// a two-stage elastic valid/ready pipeline (stage 1 = level/index, stage 2 =
// output register).
//
// Ports:
//   clk, nrst                  clock (rising edge), async active-low reset
//   mapping_hv_segment         bank write in progress, blocks new input
//   level_hvs_reg_0..8         level HV bank contents, one port per level
//   idx_clr                    synchronous frame restart of the index counter
//   in_valid/in_ready/in_feat  input sample handshake
//   out_valid/out_ready        output handshake
//   out_hv, out_level          selected level HV and its level
//   out_idx, out_last          feature index, high on the frame's last index
//   idle                       both pipeline stages empty
module qtz_level_reader #(
  parameter int HV_DIM   = 1024,
  parameter int FEAT_W   = 8,
  parameter int NUM_FEAT = 617,
  parameter int IDX_W    = $clog2(NUM_FEAT)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              mapping_hv_segment,
  input  logic [HV_DIM-1:0] level_hvs_reg_0,
  input  logic [HV_DIM-1:0] level_hvs_reg_1,
  input  logic [HV_DIM-1:0] level_hvs_reg_2,
  input  logic [HV_DIM-1:0] level_hvs_reg_3,
  input  logic [HV_DIM-1:0] level_hvs_reg_4,
  input  logic [HV_DIM-1:0] level_hvs_reg_5,
  input  logic [HV_DIM-1:0] level_hvs_reg_6,
  input  logic [HV_DIM-1:0] level_hvs_reg_7,
  input  logic [HV_DIM-1:0] level_hvs_reg_8,
  input  logic              idx_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FEAT_W-1:0] in_feat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] out_hv,
  output logic [3:0]        out_level,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              idle
);

  localparam int PROD_W = FEAT_W + 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  // Quantize a sample: (feat * 9) >> FEAT_W. The product is FEAT_W+4 bits
  // wide, so the shift leaves exactly its top four bits (always 0..8).
  function automatic logic [3:0] quantize(input logic [FEAT_W-1:0] feat);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(feat) * PROD_W'(9);
    return prod[PROD_W-1 -: 4];
  endfunction

  logic              s1_valid_r;
  logic [3:0]        s1_lvl_r;
  logic [IDX_W-1:0]  s1_idx_r;
  logic              s1_last_r;
  logic [IDX_W-1:0]  idx_cnt_r;

  logic              s2_adv_s;
  logic              accept_s;
  logic              s2_load_s;
  logic [IDX_W-1:0]  smp_idx_s;
  logic [IDX_W-1:0]  idx_next_s;
  logic [HV_DIM-1:0] sel_hv_s;

  // Handshake decode: stage 2 can advance when empty or drained this cycle.
  always_comb begin
    s2_adv_s  = !out_valid || out_ready;
    in_ready  = nrst && (!s1_valid_r || s2_adv_s) && !mapping_hv_segment;
    accept_s  = in_valid && in_ready;
    s2_load_s = s1_valid_r && s2_adv_s;
    idle      = !s1_valid_r && !out_valid;
  end

  // Index of the sample being accepted and the counter's next value.
  // idx_clr together with an accept gives that sample index 0.
  always_comb begin
    smp_idx_s  = idx_cnt_r;
    idx_next_s = idx_cnt_r;
    if (idx_clr) begin
      smp_idx_s = '0;
    end else begin
      smp_idx_s = idx_cnt_r;
    end
    if (accept_s) begin
      if (smp_idx_s == LAST_IDX) begin
        idx_next_s = '0;
      end else begin
        idx_next_s = smp_idx_s + IDX_W'(1);
      end
    end else if (idx_clr) begin
      idx_next_s = '0;
    end else begin
      idx_next_s = idx_cnt_r;
    end
  end

  // Bank read mux. The bank is sampled when stage 2 loads.
  always_comb begin
    sel_hv_s = '0;
    case (s1_lvl_r)
      4'd0:    sel_hv_s = level_hvs_reg_0;
      4'd1:    sel_hv_s = level_hvs_reg_1;
      4'd2:    sel_hv_s = level_hvs_reg_2;
      4'd3:    sel_hv_s = level_hvs_reg_3;
      4'd4:    sel_hv_s = level_hvs_reg_4;
      4'd5:    sel_hv_s = level_hvs_reg_5;
      4'd6:    sel_hv_s = level_hvs_reg_6;
      4'd7:    sel_hv_s = level_hvs_reg_7;
      4'd8:    sel_hv_s = level_hvs_reg_8;
      default: sel_hv_s = '0;
    endcase
  end

  // Feature index counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx_cnt_r <= '0;
    end else begin
      idx_cnt_r <= idx_next_s;
    end
  end

  // Stage 1: quantized level, index and last flag captured on accept.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_valid_r <= 1'b0;
      s1_lvl_r   <= 4'd0;
      s1_idx_r   <= '0;
      s1_last_r  <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_lvl_r   <= quantize(in_feat);
      s1_idx_r   <= smp_idx_s;
      s1_last_r  <= (smp_idx_s == LAST_IDX);
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2: output register. Data holds while stalled or after draining.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid <= 1'b0;
      out_hv    <= '0;
      out_level <= 4'd0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (s2_load_s) begin
      out_valid <= 1'b1;
      out_hv    <= sel_hv_s;
      out_level <= s1_lvl_r;
      out_idx   <= s1_idx_r;
      out_last  <= s1_last_r;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
